// File: rtl/seq_detector_param.sv
// seq_detector_param: Mealy serial pattern detector with a loadable pattern register.
// Define SEQ_DET_CNT_EN to add the saturating match_cnt output.
module seq_detector_param #(
  parameter int                PAT_W     = 4,
  parameter logic [PAT_W-1:0]  RESET_PAT = PAT_W'(4'b1010),
  parameter int                CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             dout
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-2:0]  hist_q;
  logic [FILL_W-1:0] fill_q;

  logic [PAT_W-1:0]  window;
  logic              full;
  logic              match;

  // The incoming bit completes the window combinationally, so dout has zero latency.
  assign window = {hist_q, din};
  assign full   = (fill_q == FILL_LAST);
  assign match  = reset & din_valid & ~pat_load & full & (window == pat_q);
  assign dout   = match;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q  <= RESET_PAT;
      hist_q <= '0;
      fill_q <= '0;
    end else if (pat_load) begin
      pat_q  <= pat_in;
      hist_q <= '0;
      fill_q <= '0;
    end else if (din_valid) begin
      hist_q <= window[PAT_W-2:0];
      if (match) begin
        // Overlap keeps the window full so the match suffix can start the next one.
        fill_q <= overlap ? FILL_LAST : '0;
      end else if (fill_q < FILL_LAST) begin
        fill_q <= fill_q + 1'b1;
      end else begin
        fill_q <= FILL_LAST;
      end
    end
  end

`ifdef SEQ_DET_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      match_cnt <= '0;
    end else if (pat_load) begin
      match_cnt <= '0;
    end else if (match && !(&match_cnt)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`endif

endmodule
